// File: rtl/fifo_empty_rd_if.sv
// Read-side bundle of the async FIFO: synchronized write pointer in, memory read port,
// and the registered valid/ready output stage.
interface fifo_empty_rd_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH:0]   write_ptr;
    logic [DATA_WIDTH-1:0] rd_mem_data;
    logic                  r_ready;
    logic [ADDR_WIDTH-1:0] rdaddress;
    logic [ADDR_WIDTH:0]   read_ptr;
    logic                  empty;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    modport master (
        output write_ptr, rd_mem_data, r_ready,
        input  rdaddress, read_ptr, empty, r_data, r_valid
    );

    modport slave (
        input  write_ptr, rd_mem_data, r_ready,
        output rdaddress, read_ptr, empty, r_data, r_valid
    );
endinterface

// File: rtl/fifo_empty_rd.sv
// Read domain of an async FIFO: write-pointer synchronizer, gray read pointer,
// empty detect and a one-entry registered output stage with full throughput.
module fifo_empty_rd #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic           rclk,
    input  logic           rrst_n,
    fifo_empty_rd_if.slave bus
);
    logic [ADDR_WIDTH:0]   sync1;
    logic [ADDR_WIDTH:0]   synch_writeptr;
    logic [ADDR_WIDTH:0]   rbin;
    logic [ADDR_WIDTH:0]   rbin_next;
    logic [ADDR_WIDTH:0]   read_ptr_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic                  r_valid_q;
    logic                  empty_c;
    logic                  fetch;

    // Gray compare is exact equality, so it stays correct across the pointer wrap.
    assign empty_c   = (read_ptr_q == synch_writeptr);
    assign fetch     = !empty_c && (!r_valid_q || bus.r_ready);
    assign rbin_next = rbin + {{ADDR_WIDTH{1'b0}}, fetch};

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            sync1          <= '0;
            synch_writeptr <= '0;
        end else begin
            sync1          <= bus.write_ptr;
            synch_writeptr <= sync1;
        end
    end

    // read_ptr is registered so the write domain never samples combinational gray.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin       <= '0;
            read_ptr_q <= '0;
        end else begin
            rbin       <= rbin_next;
            read_ptr_q <= rbin_next ^ (rbin_next >> 1);
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else if (fetch) begin
            r_data_q  <= bus.rd_mem_data;
            r_valid_q <= 1'b1;
        end else if (r_valid_q && bus.r_ready) begin
            r_valid_q <= 1'b0;
        end
    end

    assign bus.rdaddress = rbin[ADDR_WIDTH-1:0];
    assign bus.read_ptr  = read_ptr_q;
    assign bus.empty     = empty_c;
    assign bus.r_data    = r_data_q;
    assign bus.r_valid   = r_valid_q;
endmodule

// File: tb/tb_fifo_empty_rd.sv
// Bench for fifo_empty_rd: directed vector table, multi-cycle corner sequences,
// and random traffic against a count/queue reference model.
module tb_fifo_empty_rd;
    logic       rclk = 1'b0;
    logic       rrst_n = 1'b0;
    logic [7:0] mem [8];

    fifo_empty_rd_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();

    fifo_empty_rd #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    always #5 rclk = ~rclk;
    assign bus.rd_mem_data = mem[bus.rdaddress];

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit         rst;
        logic [3:0] wp;
        bit         rdy;
        bit         ev;
        logic [7:0] ed;
        logic [3:0] erp;
        logic [2:0] erd;
        bit         ee;
    } vec_t;
    vec_t vecs[$];

    // Reference model: binary counts modulo 16 plus a queue of written words.
    int  wcnt, rcnt, s1, s2;
    bit  mvalid;
    logic [7:0] mdata;
    logic [7:0] q[$];

    function automatic logic [3:0] gray(input int v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input bit rst, input logic [3:0] wp, input bit rdy, input bit ev,
                           input logic [7:0] ed, input logic [3:0] erp, input logic [2:0] erd,
                           input bit ee);
        vec_t v;
        v.rst = rst; v.wp = wp; v.rdy = rdy; v.ev = ev;
        v.ed = ed; v.erp = erp; v.erd = erd; v.ee = ee;
        vecs.push_back(v);
    endtask

    task automatic model_clear();
        wcnt = 0; rcnt = 0; s1 = 0; s2 = 0;
        mvalid = 1'b0; mdata = 8'h00;
        q.delete();
    endtask

    task automatic model_edge(input bit rdy);
        bit fetch;
        fetch = (rcnt != s2) && (!mvalid || rdy);
        s2 = s1;
        s1 = wcnt;
        if (fetch) begin
            mdata  = q.pop_front();
            mvalid = 1'b1;
            rcnt   = (rcnt + 1) % 16;
        end else if (mvalid && rdy) begin
            mvalid = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".read_ptr"},  32'(bus.read_ptr),  32'(gray(rcnt)));
        check({tag, ".rdaddress"}, 32'(bus.rdaddress), 32'(rcnt % 8));
        check({tag, ".empty"},     32'(bus.empty),     32'(rcnt == s2));
        check({tag, ".r_valid"},   32'(bus.r_valid),   32'(mvalid));
        check({tag, ".r_data"},    32'(bus.r_data),    32'(mdata));
    endtask

    task automatic push(input logic [7:0] d);
        mem[wcnt % 8] = d;
        q.push_back(d);
        wcnt = (wcnt + 1) % 16;
    endtask

    task automatic cycle(input bit rdy, input string tag);
        bus.r_ready   = rdy;
        bus.write_ptr = gray(wcnt);
        model_edge(rdy);
        @(posedge rclk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        bus.r_ready = 1'b0;
        model_clear();
        bus.write_ptr = 4'b0000;
        @(posedge rclk);
        #1;
        check_all("reset");
        rrst_n = 1'b1;
    endtask

    initial begin
        int n;
        bus.r_ready = 1'b0;
        bus.write_ptr = 4'($urandom_range(15));
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h5A; mem[3] = 8'hC3;

        // Reset, single word, reset again, then backpressure / last-word overlap.
        add_vec(1, 4'($urandom_range(15)), 0, 0, 8'h00, 4'b0000, 3'd0, 1);
        add_vec(0, 4'b0001, 0, 0, 8'h00, 4'b0000, 3'd0, 1);
        add_vec(0, 4'b0001, 0, 0, 8'h00, 4'b0000, 3'd0, 0);
        add_vec(0, 4'b0001, 0, 1, 8'hA5, 4'b0001, 3'd1, 1);
        add_vec(0, 4'b0001, 0, 1, 8'hA5, 4'b0001, 3'd1, 1);
        add_vec(0, 4'b0001, 1, 0, 8'hA5, 4'b0001, 3'd1, 1);
        add_vec(1, 4'b0000, 0, 0, 8'h00, 4'b0000, 3'd0, 1);
        add_vec(0, 4'b0010, 0, 0, 8'h00, 4'b0000, 3'd0, 1);
        add_vec(0, 4'b0010, 0, 0, 8'h00, 4'b0000, 3'd0, 0);
        add_vec(0, 4'b0010, 0, 1, 8'hA5, 4'b0001, 3'd1, 0);
        for (int i = 0; i < 10; i++)
            add_vec(0, 4'b0010, 0, 1, 8'hA5, 4'b0001, 3'd1, 0);
        add_vec(0, 4'b0010, 1, 1, 8'h3C, 4'b0011, 3'd2, 0);
        add_vec(0, 4'b0010, 1, 1, 8'h5A, 4'b0010, 3'd3, 1);
        add_vec(0, 4'b0010, 1, 0, 8'h5A, 4'b0010, 3'd3, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            rrst_n        = !vecs[i].rst;
            bus.write_ptr = vecs[i].wp;
            bus.r_ready   = vecs[i].rdy;
            @(posedge rclk);
            #1;
            check($sformatf("vec%0d.read_ptr", i),  32'(bus.read_ptr),  32'(vecs[i].erp));
            check($sformatf("vec%0d.rdaddress", i), 32'(bus.rdaddress), 32'(vecs[i].erd));
            check($sformatf("vec%0d.empty", i),     32'(bus.empty),     32'(vecs[i].ee));
            check($sformatf("vec%0d.r_valid", i),   32'(bus.r_valid),   32'(vecs[i].ev));
            check($sformatf("vec%0d.r_data", i),    32'(bus.r_data),    32'(vecs[i].ed));
        end

        // Streaming 20 words through the pointer wrap at full rate.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            push(8'(8'h10 + i * 7));
            cycle(1'b1, "stream");
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, "drain");
        check("stream.final_ptr", 32'(bus.read_ptr), 32'(4'b0110));
        check("stream.final_valid", 32'(bus.r_valid), 32'(0));

        // Mid-stream asynchronous reset with a held word at read_ptr 0110.
        do_reset();
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        n = 0;
        while (rcnt != 4 && n < 30) begin
            cycle(1'b1, "pre_rst");
            n++;
        end
        cycle(1'b0, "hold");
        cycle(1'b0, "hold");
        check("midrst.read_ptr_before", 32'(bus.read_ptr), 32'(4'b0110));
        check("midrst.valid_before", 32'(bus.r_valid), 32'(1));
        rrst_n = 1'b0;
        #2;
        check("midrst.read_ptr", 32'(bus.read_ptr), 32'(0));
        check("midrst.rdaddress", 32'(bus.rdaddress), 32'(0));
        check("midrst.r_valid", 32'(bus.r_valid), 32'(0));
        check("midrst.r_data", 32'(bus.r_data), 32'(0));
        check("midrst.empty", 32'(bus.empty), 32'(1));
        model_clear();
        bus.write_ptr = 4'b0000;
        @(posedge rclk);
        #1;
        rrst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b1, "post_rst");
        check("midrst.valid_after", 32'(bus.r_valid), 32'(0));

        // Random traffic with writes limited to free entries.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (q.size() < 8 && $urandom_range(1) == 1) push(8'($urandom_range(255)));
            cycle(1'($urandom_range(3) != 0 ? 1 : 0) & 1'($urandom_range(1)) | 1'($urandom_range(1)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_empty_rd.md
FIFO_EMPTY_RD -- requirements
Module: fifo_empty_rd

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 3, which sets the memory address width (depth 2^ADDR_WIDTH = 8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, which sets the data word width.
REQ-003 rclk  input  1  read-domain clock; the block SHALL use one clock only, and all state updates on its rising edge.
REQ-004 rrst_n  input  1  asynchronous, active-low reset.
REQ-005 write_ptr  input  ADDR_WIDTH+1  gray-coded write pointer from the write domain, asynchronous to rclk.
REQ-006 rd_mem_data  input  DATA_WIDTH  memory word at rdaddress (combinational memory read).
REQ-007 r_ready  input  1  consumer accepts r_data this cycle.
REQ-008 rdaddress  output  ADDR_WIDTH  memory read address = binary read count[ADDR_WIDTH-1:0].
REQ-009 read_ptr  output  ADDR_WIDTH+1  registered gray read pointer, sent to the write domain.
REQ-010 empty  output  1  no unread memory entry is visible in the read domain.
REQ-011 r_data  output  DATA_WIDTH  registered output word.
REQ-012 r_valid  output  1  r_data holds a valid, not-yet-accepted word.

Function
REQ-013 write_ptr SHALL pass through a 2-flop synchronizer (sync1 -> synch_writeptr); no logic is allowed between the flops.
REQ-014 The read count SHALL be an (ADDR_WIDTH+1)-bit binary register, rbin.
REQ-015 read_ptr SHALL be a register loaded with gray(rbin_next) = rbin_next ^ (rbin_next >> 1) on the same edge as rbin; no combinational gray goes out of the block.
REQ-016 empty SHALL be (read_ptr == synch_writeptr), combinational from registers only.
REQ-017 fetch = !empty && (!r_valid || r_ready).
REQ-018 On fetch, rbin SHALL increment, read_ptr/rdaddress SHALL advance, r_data SHALL load rd_mem_data, and r_valid SHALL be set to 1.
REQ-019 If r_valid && r_ready && !fetch, r_valid SHALL clear to 0 and r_data SHALL hold its value.
REQ-020 If r_valid && !r_ready, r_data, r_valid and rbin SHALL all hold (no overwrite).
REQ-021 r_ready while r_valid=0 SHALL have no effect.
REQ-022 Simultaneous accept and fetch SHALL keep r_valid=1 and load the next word: one word per cycle sustained throughput.
REQ-023 rbin SHALL wrap from 2^(ADDR_WIDTH+1)-1 to 0 modulo (for ADDR_WIDTH=3, gray 1000 -> 0000), and empty SHALL stay correct across the wrap.
REQ-024 Latency: if write_ptr changes before rclk edge N with the FIFO idle, sync1 updates at N, synch_writeptr at N+1, and r_valid SHALL rise at N+2.
REQ-025 empty SHALL deassert no earlier than edge N+1; the block SHALL never fetch from an unwritten location.
REQ-026 r_data SHALL change only on a fetch.

Reset
REQ-027 On rrst_n low, the block SHALL immediately clear sync1, synch_writeptr, rbin, read_ptr (all 0), r_data (0) and r_valid (0); outputs then read rdaddress=0 and empty=1.
REQ-028 Reset asserted mid-stream SHALL discard any held r_data word and all pending entries; after release, the block SHALL resume from pointer 0.
REQ-029 Reset release SHALL take effect on the next rclk edge; no fetch SHALL occur on the release edge unless synch_writeptr != 0.

Verification
REQ-030 Reset: hold rrst_n=0 with arbitrary write_ptr -> read_ptr=0000, rdaddress=000, r_valid=0, empty=1, r_data=0x00.
REQ-031 Single word: write_ptr 0000->0001 with rd_mem_data=0xA5 and r_ready=0 -> r_valid=1 and r_data=0xA5 at the 3rd rclk edge, read_ptr=0001, empty=1.
REQ-032 Backpressure: write_ptr advanced to 0010 (3 entries), r_ready=0 -> exactly one fetch, read_ptr=0001, r_data stable for 10 cycles; then r_ready=1 -> two more words on consecutive cycles, read_ptr=0010, r_valid drops after the last accept.
REQ-033 Wrap: stream 20 words with r_ready=1 and write_ptr advanced in step -> read_ptr passes 1000->0000 (rbin 1111->0000), data order preserved, no spurious empty or extra fetch.
REQ-034 Last-word overlap: r_valid=1 with one memory entry left and r_ready=1 -> fetch and accept on the same edge, r_valid stays 1; next edge with r_ready=1 -> r_valid=0, empty=1.
REQ-035 Mid-stream reset: assert rrst_n=0 while r_valid=1, read_ptr=0110 -> all registers 0 asynchronously (checked before the next rclk edge), then after release with write_ptr=0000 -> r_valid stays 0.
